// File: rtl/serial_adder_pkg.sv
// -----------------------------------------------------------------------------
// serial_adder_pkg
// Shared definitions for the bit-serial adder:
//   - serial_adder_state_e : control FSM states (IDLE, RUN, DONE)
//   - WIDTH_MIN            : smallest legal operand width
// -----------------------------------------------------------------------------
package serial_adder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } serial_adder_state_e;

    localparam int WIDTH_MIN = 2;

endpackage

// File: rtl/serial_adder_fa_cell.sv
// -----------------------------------------------------------------------------
// fa_cell
// Combinational 1-bit full adder. This is the only arithmetic element of the
// serial adder.
// Ports:
//   a, b, cin : input bits
//   s         : sum bit   = a ^ b ^ cin
//   c         : carry out = majority(a, b, cin)
// -----------------------------------------------------------------------------
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic c
);

    assign s = a ^ b ^ cin;
    assign c = (a & b) | (b & cin) | (cin & a);

endmodule

// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
// Bit-serial adder. Operands are taken through a valid/ready handshake and
// added LSB-first, one bit per clock, through a single full-adder cell and a
// carry flip-flop. The result is offered through a second valid/ready
// handshake and is held for as long as the consumer stalls.
//
// Parameters:
//   WIDTH      : operand/sum width, >= WIDTH_MIN (2)
// Ports:
//   clk        : clock, rising edge
//   rst        : synchronous active-high reset
//   in_valid   : operands valid
//   in_ready   : accepting operands (IDLE only, low while rst is high)
//   a, b       : WIDTH-bit operands
//   cin        : carry-in
//   sub        : subtract mode (only when SERIAL_ADDER_SUB_EN is defined)
//   out_valid  : sum/cout hold a completed result
//   out_ready  : consumer accepts the result
//   sum        : WIDTH-bit registered result
//   cout       : registered carry out of the MSB
//   busy       : high in RUN and DONE
//
// Build option: define SERIAL_ADDER_SUB_EN to add the sub port and a - b mode.
// -----------------------------------------------------------------------------
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    if (WIDTH < WIDTH_MIN) begin : g_width_check
        $error("serial_adder: WIDTH (%0d) must be >= %0d", WIDTH, WIDTH_MIN);
    end

    serial_adder_state_e state_q, state_d;
    logic [WIDTH-1:0]    a_sr_q, a_sr_d;
    logic [WIDTH-1:0]    b_sr_q, b_sr_d;
    logic [WIDTH-1:0]    sum_sr_q, sum_sr_d;
    logic                carry_q, carry_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                idle_ready;
    logic                fa_s;
    logic                fa_c;

    fa_cell u_fa (
        .a   (a_sr_q[0]),
        .b   (b_sr_q[0]),
        .cin (carry_q),
        .s   (fa_s),
        .c   (fa_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            sum_sr_q <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            a_sr_q   <= a_sr_d;
            b_sr_q   <= b_sr_d;
            sum_sr_q <= sum_sr_d;
            carry_q  <= carry_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        a_sr_d     = a_sr_q;
        b_sr_d     = b_sr_q;
        sum_sr_d   = sum_sr_q;
        carry_d    = carry_q;
        cnt_d      = cnt_q;
        idle_ready = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                idle_ready = 1'b1;
                if (in_valid) begin
                    a_sr_d = a;
`ifdef SERIAL_ADDER_SUB_EN
                    // a - b as a + ~b + 1; the caller's cin is irrelevant here.
                    if (sub) begin
                        b_sr_d  = ~b;
                        carry_d = 1'b1;
                    end else begin
                        b_sr_d  = b;
                        carry_d = cin;
                    end
`else
                    b_sr_d  = b;
                    carry_d = cin;
`endif
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end

            ST_RUN: begin
                busy = 1'b1;
                // Sum bits enter at the MSB so that after WIDTH steps the
                // first (LSB) result bit has reached position 0.
                sum_sr_d = {fa_s, sum_sr_q[WIDTH-1:1]};
                a_sr_d   = a_sr_q >> 1;
                b_sr_d   = b_sr_q >> 1;
                carry_d  = fa_c;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_DONE;
                end
            end

            ST_DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // rst gates in_ready combinationally so no producer sees a handshake that
    // the reset is about to discard.
    assign in_ready = idle_ready & ~rst;
    assign sum      = sum_sr_q;
    assign cout     = carry_q;

endmodule

// File: tb/tb_serial_adder.sv
// -----------------------------------------------------------------------------
// tb_serial_adder
// Self-checking bench for serial_adder. Two instances share the clock and
// reset: WIDTH=8 for directed/random operations and WIDTH=3 for an
// exhaustive operand sweep. Expected results come from plain integer
// arithmetic on the operands.
// -----------------------------------------------------------------------------
module tb_serial_adder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       in_valid8 = 1'b0, in_ready8, out_valid8, out_ready8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0, sum8;
    logic       cin8 = 1'b0, sub8 = 1'b0, cout8, busy8;

    logic       in_valid3 = 1'b0, in_ready3, out_valid3, out_ready3 = 1'b1;
    logic [2:0] a3 = '0, b3 = '0, sum3;
    logic       cin3 = 1'b0, sub3 = 1'b0, cout3, busy3;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8)) dut8 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid8),
        .in_ready  (in_ready8),
        .a         (a8),
        .b         (b8),
        .cin       (cin8),
`ifdef SERIAL_ADDER_SUB_EN
        .sub       (sub8),
`endif
        .out_valid (out_valid8),
        .out_ready (out_ready8),
        .sum       (sum8),
        .cout      (cout8),
        .busy      (busy8)
    );

    serial_adder #(.WIDTH(3)) dut3 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid3),
        .in_ready  (in_ready3),
        .a         (a3),
        .b         (b3),
        .cin       (cin3),
`ifdef SERIAL_ADDER_SUB_EN
        .sub       (sub3),
`endif
        .out_valid (out_valid3),
        .out_ready (out_ready3),
        .sum       (sum3),
        .cout      (cout3),
        .busy      (busy3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One WIDTH=8 operation. hold = cycles out_ready stays low in DONE;
    // poke = keep in_valid high with junk operands during RUN and DONE.
    task automatic op8(input logic [7:0] av, input logic [7:0] bv, input logic cv,
                       input logic sv, input int hold, input bit poke, input string tag);
        logic [8:0] exp;
        int k;
        if (sv) exp = {1'b0, av} - {1'b0, bv} + 9'd256;
        else    exp = {1'b0, av} + {1'b0, bv} + {8'd0, cv};

        k = 0;
        while (!in_ready8 && k < 50) begin @(negedge clk); k++; end
        chk({tag, "_in_ready"}, in_ready8, 1);
        a8 = av; b8 = bv; cin8 = cv; sub8 = sv; in_valid8 = 1'b1;
        @(posedge clk);                       // accept edge
        @(negedge clk);
        in_valid8 = poke; a8 = 8'($urandom); b8 = 8'($urandom);
        k = 1;
        while (!out_valid8 && k < 40) begin
            if (poke) chk({tag, "_run_in_ready"}, in_ready8, 0);
            @(negedge clk);
            k++;
        end
        chk({tag, "_latency"}, k, 9);
        for (int i = 0; i < hold; i++) begin
            chk({tag, "_hold_valid"}, out_valid8, 1);
            chk({tag, "_hold_sum"}, sum8, exp[7:0]);
            chk({tag, "_hold_cout"}, cout8, exp[8]);
            chk({tag, "_done_in_ready"}, in_ready8, 0);
            @(negedge clk);
        end
        chk({tag, "_sum"}, sum8, exp[7:0]);
        chk({tag, "_cout"}, cout8, exp[8]);
        chk({tag, "_busy"}, busy8, 1);
        out_ready8 = 1'b1;
        @(posedge clk);                       // consume edge
        @(negedge clk);
        chk({tag, "_post_valid"}, out_valid8, 0);
        chk({tag, "_post_busy"}, busy8, 0);    // in_valid at consume edge ignored
        chk({tag, "_post_in_ready"}, in_ready8, 1);
        out_ready8 = 1'b0; in_valid8 = 1'b0;
        $display("op8 %s a=%02h b=%02h cin=%0d sub=%0d -> sum=%02h cout=%0d", tag, av, bv, cv, sv, exp[7:0], exp[8]);
    endtask

    task automatic op3(input logic [2:0] av, input logic [2:0] bv, input logic cv);
        logic [3:0] exp;
        int k;
        exp = {1'b0, av} + {1'b0, bv} + {3'd0, cv};
        k = 0;
        while (!in_ready3 && k < 20) begin @(negedge clk); k++; end
        a3 = av; b3 = bv; cin3 = cv; in_valid3 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid3 = 1'b0;
        k = 1;
        while (!out_valid3 && k < 20) begin @(negedge clk); k++; end
        chk("w3_result", {28'd0, cout3, sum3}, {28'd0, exp});
        @(posedge clk);
        @(negedge clk);
    endtask

    logic [7:0] ra, rb;
    logic       rc, rs;

    initial begin
        // Power-up reset, held for two cycles.
        rst = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("rst_in_ready", in_ready8, 0);
            chk("rst_out_valid", out_valid8, 0);
            chk("rst_busy", busy8, 0);
            chk("rst_sum", sum8, 0);
            chk("rst_cout", cout8, 0);
        end
        rst = 1'b0;
        @(negedge clk);
        chk("rst_release_in_ready", in_ready8, 1);
        $display("reset from power-up done");

        op8(8'h5A, 8'h3C, 1'b0, 1'b0, 0, 1'b0, "basic");
        op8(8'hFF, 8'h01, 1'b1, 1'b0, 5, 1'b1, "backpressure");

        // Reset in the middle of RUN.
        a8 = 8'hAA; b8 = 8'h55; cin8 = 1'b1; in_valid8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid8 = 1'b0;
        repeat (3) @(negedge clk);            // now in RUN cycle 4
        rst = 1'b1;
        chk("midrst_in_ready", in_ready8, 0);
        repeat (2) begin
            @(negedge clk);
            chk("midrst_busy", busy8, 0);
            chk("midrst_out_valid", out_valid8, 0);
            chk("midrst_sum", sum8, 0);
            chk("midrst_cout", cout8, 0);
        end
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("midrst_no_pulse", out_valid8, 0);
        end
        chk("midrst_idle", in_ready8, 1);
        $display("reset mid-RUN done");
        op8(8'h0F, 8'hF0, 1'b1, 1'b0, 0, 1'b0, "after_rst");

`ifdef SERIAL_ADDER_SUB_EN
        op8(8'h10, 8'h01, 1'b0, 1'b1, 0, 1'b0, "sub_pos");
        op8(8'h01, 8'h02, 1'b1, 1'b1, 2, 1'b0, "sub_borrow");
`endif

        // Exhaustive WIDTH=3 sweep.
        for (int ia = 0; ia < 8; ia++)
            for (int ib = 0; ib < 8; ib++)
                for (int ic = 0; ic < 2; ic++)
                    op3(3'(ia), 3'(ib), 1'(ic));
        $display("width-3 sweep done");

        // Random WIDTH=8 operations with random stall and poke.
        for (int n = 0; n < 30; n++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rc = 1'($urandom);
            rs = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
            rs = 1'($urandom);
`endif
            op8(ra, rb, rc, rs, int'($urandom_range(0, 3)), bit'($urandom), "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
